// File: rtl/nfc_rng_descr.sv
// Read-path de-randomizer: regenerates the program-path LFSR pattern from the
// session seed, XORs it onto raw flash words and flags erased pages.
module nfc_rng_descr #(
  parameter int PAGE_WORDS = 1024,
  parameter int ERASE_THR  = 4,
  parameter int CW         = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        bypass,
  input  logic [31:0] seed,
  input  logic        in_vld,
  input  logic [15:0] in_dat,
  output logic        in_rdy,
  output logic        out_vld,
  output logic [15:0] out_dat,
  input  logic        out_rdy,
  output logic        page_done,
  output logic        page_erased
);

  localparam int NW = $clog2(ERASE_THR + 2);
  localparam logic [CW-1:0] LAST_WORD = CW'(PAGE_WORDS - 1);
  localparam logic [NW-1:0] NFF_SAT   = NW'(ERASE_THR + 1);
  localparam logic [NW-1:0] NFF_THR   = NW'(ERASE_THR);

  logic          en_dly;
  logic [31:0]   lfsr;
  logic          sel;
  logic [CW-1:0] wcnt;
  logic [NW-1:0] nff;

  logic          start;
  logic          accept;
  logic          page_end;
  logic [15:0]   pattern;
  logic [NW-1:0] nff_nxt;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[6] ^ s[4] ^ s[2] ^ s[1] ^ s[0]};
  endfunction

  // Non-FFFF count only needs to resolve "above threshold", so it saturates.
  function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] c, input logic hit);
    return (hit && c != NFF_SAT) ? c + 1'b1 : c;
  endfunction

  assign start    = en & ~en_dly;
  assign in_rdy   = en & en_dly & (~out_vld | out_rdy);
  assign accept   = in_vld & in_rdy;
  assign pattern  = sel ? lfsr[31:16] : lfsr[15:0];
  assign nff_nxt  = sat_inc(nff, in_dat != 16'hFFFF);
  assign page_end = accept && (wcnt == LAST_WORD);

  // Stage boundary: raw input -> registered descrambled word and page verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_dly      <= 1'b0;
      lfsr        <= '0;
      sel         <= 1'b1;
      wcnt        <= '0;
      nff         <= '0;
      out_vld     <= 1'b0;
      out_dat     <= '0;
      page_done   <= 1'b0;
      page_erased <= 1'b0;
    end else begin
      en_dly    <= en;
      page_done <= 1'b0;
      if (start) begin
        lfsr        <= seed;
        sel         <= 1'b1;
        wcnt        <= '0;
        nff         <= '0;
        page_erased <= 1'b0;
        out_vld     <= 1'b0;
      end else if (!en) begin
        out_vld <= 1'b0;
      end else if (accept) begin
        out_dat <= bypass ? in_dat : (in_dat ^ pattern);
        out_vld <= 1'b1;
        if (!bypass) begin
          if (sel) lfsr <= lfsr_step(lfsr);
          sel <= ~sel;
        end
        if (page_end) begin
          wcnt        <= '0;
          nff         <= '0;
          page_done   <= 1'b1;
          page_erased <= (nff_nxt <= NFF_THR);
        end else begin
          wcnt <= wcnt + 1'b1;
          nff  <= nff_nxt;
        end
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nfc_rng_descr.sv
// Randomized and directed bench for nfc_rng_descr against a word-index based
// pattern model and a page/erase scoreboard.
module tb_nfc_rng_descr;

  localparam int PW  = 8;
  localparam int THR = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        bypass;
  logic [31:0] seed;
  logic        in_vld;
  logic [15:0] in_dat;
  logic        in_rdy;
  logic        out_vld;
  logic [15:0] out_dat;
  logic        out_rdy;
  logic        page_done;
  logic        page_erased;

  nfc_rng_descr #(.PAGE_WORDS(PW), .ERASE_THR(THR), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bypass(bypass), .seed(seed),
    .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy),
    .page_done(page_done), .page_erased(page_erased)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern for the k-th non-bypassed word of a session:
  // k=0 -> seed[31:16], then S1[15:0], S1[31:16], S2[15:0], ...
  function automatic logic [15:0] pat(input logic [31:0] s, input int k);
    logic [31:0] st;
    int m;
    st = s;
    m  = (k + 1) / 2;
    for (int i = 0; i < m; i++) st = {st[30:0], ^(st & 32'h8000_0057)};
    return (k % 2 == 0) ? st[31:16] : st[15:0];
  endfunction

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] out_log[$];
  logic [31:0] seed_m;
  logic        en_q, exp_pd, exp_pe, rdy_m;
  int          k_m, wc_m, nff_m;
  int          acc_cnt = 0;
  int          pd_cnt  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      en_q = 1'b0; exp_pd = 1'b0; exp_pe = 1'b0;
      k_m = 0; wc_m = 0; nff_m = 0;
    end else begin
      rdy_m = en && en_q && (q.size() == 0 || out_rdy);
      chk("out_vld", out_vld, q.size() != 0);
      if (q.size() != 0) chk("out_dat", out_dat, q[0]);
      chk("in_rdy", in_rdy, rdy_m);
      chk("page_done", page_done, exp_pd);
      chk("page_erased", page_erased, exp_pe);
      if (page_done) pd_cnt++;
      exp_pd = 1'b0;
      if (out_vld && out_rdy) out_log.push_back(out_dat);
      if (out_rdy && q.size() != 0) void'(q.pop_front());
      if (!en) begin
        q.delete();
      end else if (!en_q) begin
        seed_m = seed; k_m = 0; wc_m = 0; nff_m = 0; exp_pe = 1'b0;
        q.delete();
      end else if (in_vld && rdy_m) begin
        acc_cnt++;
        if (bypass) q.push_back(in_dat);
        else begin
          q.push_back(in_dat ^ pat(seed_m, k_m));
          k_m++;
        end
        wc_m++;
        if (in_dat != 16'hFFFF) nff_m++;
        if (wc_m == PW) begin
          exp_pd = 1'b1;
          exp_pe = (nff_m <= THR);
          wc_m = 0; nff_m = 0;
        end
      end
      en_q = en;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [31:0] s);
    in_vld = 1'b0; bypass = 1'b0; out_rdy = 1'b1; en = 1'b0;
    step(2);
    seed = s; en = 1'b1;
    step(1);
    out_log.delete();
  endtask

  task automatic send_word(input logic [15:0] d, input logic byp);
    int base;
    int waited;
    base = acc_cnt;
    in_vld = 1'b1; in_dat = d; bypass = byp;
    waited = 0;
    while (acc_cnt == base && waited < 50) begin
      step(1);
      waited++;
    end
    if (acc_cnt == base) chk("accept_timeout", acc_cnt, base + 1);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [15:0] exp);
    logic [31:0] v;
    v = 'x;
    if (idx < out_log.size()) v = {16'h0, out_log[idx]};
    chk(tag, v, {16'h0, exp});
  endtask

  task automatic send_page(input int nonff);
    for (int i = 0; i < PW; i++)
      send_word((i >= PW - nonff) ? 16'h1234 : 16'hFFFF, 1'b0);
    in_vld = 1'b0;
    step(2);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; en = 1'b0; bypass = 1'b0; seed = '0;
    in_vld = 1'b0; in_dat = '0; out_rdy = 1'b1;
    step(3);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_page_done", page_done, 0);
    chk("rst_page_erased", page_erased, 0);
    #1 rst_n = 1'b1;
    step(2);

    // Known sequence from seed 1
    restart(32'h0000_0001);
    for (int i = 0; i < 4; i++) send_word(16'h0000, 1'b0);
    in_vld = 1'b0;
    step(3);
    chk_log("seq1_w0", 0, 16'h0000);
    chk_log("seq1_w1", 1, 16'h0003);
    chk_log("seq1_w2", 2, 16'h0000);
    chk_log("seq1_w3", 3, 16'h0006);

    // Reseed reproduces the first pattern
    restart(32'h1234_5678);
    send_word(16'hFFFF, 1'b0);
    in_vld = 1'b0;
    step(3);
    chk_log("seed_a", 0, 16'hEDCB);
    restart(32'h1234_5678);
    send_word(16'hFFFF, 1'b0);
    in_vld = 1'b0;
    step(3);
    chk_log("seed_b", 0, 16'hEDCB);

    // Bypass freezes the LFSR
    restart(32'h0000_0001);
    send_word(16'h0000, 1'b0);
    send_word(16'hA5A5, 1'b1);
    send_word(16'hA5A5, 1'b1);
    send_word(16'h0000, 1'b0);
    in_vld = 1'b0; bypass = 1'b0;
    step(3);
    chk_log("byp_w1", 1, 16'hA5A5);
    chk_log("byp_w2", 2, 16'hA5A5);
    chk_log("byp_w3", 3, 16'h0003);

    // Backpressure
    restart(32'h0000_0001);
    out_rdy = 1'b0;
    send_word(16'h0000, 1'b0);
    base = acc_cnt;
    step(5);
    chk("bp_held_acc", acc_cnt, base);
    chk("bp_held_dat", out_dat, 16'h0000);
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send_word(16'h0000, 1'b0);
    in_vld = 1'b0;
    step(3);
    chk("bp_log_len", out_log.size(), 4);
    chk_log("bp_w1", 1, 16'h0003);
    chk_log("bp_w3", 3, 16'h0006);

    // Page erase verdicts
    restart(32'hCAFE_0001);
    base = pd_cnt;
    send_page(0);
    chk("pg0_done", pd_cnt, base + 1);
    chk("pg0_erased", page_erased, 1);
    send_page(2);
    chk("pg2_erased", page_erased, 0);
    send_page(1);
    chk("pg1_erased", page_erased, 1);
    chk("pg_done_cnt", pd_cnt, base + 3);

    // Mid-page session restart discards the partial page
    restart(32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) send_word(16'hFFFF, 1'b0);
    restart(32'h0BAD_F00D);
    base = pd_cnt;
    for (int i = 0; i < PW - 1; i++) send_word(16'hFFFF, 1'b0);
    in_vld = 1'b0;
    step(3);
    chk("restart_no_done", pd_cnt, base);
    send_word(16'hFFFF, 1'b0);
    in_vld = 1'b0;
    step(2);
    chk("restart_done", pd_cnt, base + 1);

    // Randomized sessions with gaps, backpressure, bypass and enable drops
    for (int s = 0; s < 6; s++) begin
      bit ffbias;
      ffbias = (s % 2 == 0);
      restart($urandom);
      for (int c = 0; c < 200; c++) begin
        in_vld  = ($urandom_range(0, 3) != 0);
        in_dat  = (ffbias && $urandom_range(0, 9) != 0) ? 16'hFFFF : 16'($urandom);
        out_rdy = ($urandom_range(0, 3) != 0);
        bypass  = ($urandom_range(0, 9) == 0);
        en      = ($urandom_range(0, 149) != 0);
        step(1);
      end
    end

    // Asynchronous reset in the middle of traffic
    en = 1'b1; in_vld = 1'b1; out_rdy = 1'b0; in_dat = 16'h5555; bypass = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_out_dat", out_dat, 0);
    chk("arst_in_rdy", in_rdy, 0);
    chk("arst_page_erased", page_erased, 0);
    step(2);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    seed = 32'h0000_0001;
    for (int c = 0; c < 40; c++) begin
      in_vld = ($urandom_range(0, 1) != 0);
      in_dat = 16'($urandom);
      step(1);
    end
    in_vld = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nfc_rng_descr.md
Name: nfc_rng_descr

Overview:
- Read-path de-randomizer for the NAND flash controller.
- Regenerates the program-path randomizer pattern from the same 32-bit seed and XORs it onto 16-bit raw words read from flash. This restores the user data.
- Counts raw erased words (16'hFFFF) across a page and flags erased pages, so upper layers can bypass ECC and de-randomized data.
- Sits between the flash read FIFO and the ECC decoder, with valid/ready on both sides.

Parameters:
PAGE_WORDS, 1024, 16-bit words per page window.
ERASE_THR, 4, maximum count of non-FFFF raw words for a page to still be flagged erased.
CW, 11, page word counter width (must hold PAGE_WORDS).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  session enable; rising edge loads seed and clears state
bypass  input  1  1: data passes unmodified, LFSR frozen
seed  input  32  LFSR seed, sampled on en rising edge
in_vld  input  1  raw word valid
in_dat  input  16  raw word from flash
in_rdy  output  1  block accepts in_dat
out_vld  output  1  descrambled word valid
out_dat  output  16  descrambled word
out_rdy  input  1  downstream accepts out_dat
page_done  output  1  one-cycle pulse after PAGE_WORDS words are accepted
page_erased  output  1  erase verdict for the last completed page, held until next page_done or session start

Behaviour:
- Reset values: in_rdy=0, out_vld=0, out_dat=0, page_done=0, page_erased=0; LFSR=0, half-select sel=1, word counter=0, non-FF counter=0, en_dly=0.
- en_dly is en registered each cycle. Session start is en & !en_dly.
- Session start, single cycle:
  - LFSR<=seed, sel<=1, counters<=0, page_erased<=0, out_vld<=0.
  - No input is accepted in this cycle.
- While en=0: in_rdy=0, out_vld=0. A word pending at the output is dropped.
- in_rdy = en & en_dly & (!out_vld | out_rdy). A transfer occurs when in_vld & in_rdy.
- Pattern word P:
  - sel=1: P = LFSR[31:16].
  - sel=0: P = LFSR[15:0].
- LFSR step: LFSR <= {LFSR[30:0], LFSR[31]^LFSR[6]^LFSR[4]^LFSR[2]^LFSR[1]^LFSR[0]}.
- On each accepted word with bypass=0:
  - sel=1: LFSR steps and sel<=0.
  - sel=0: LFSR holds and sel<=1.
  - Resulting pattern sequence: seed[31:16], S1[15:0], S1[31:16], S2[15:0], S2[31:16], and so on.
- With bypass=1: LFSR and sel hold, and out_dat=in_dat.
- Output stage: one registered stage, latency 1 cycle.
  - On accept: out_dat<=in_dat^P (or in_dat when bypassed), out_vld<=1.
  - Cleared when out_rdy=1 and no new accept in the same cycle.
  - Accept and drain in the same cycle: new word loaded, out_vld stays 1.
  - Backpressure: out_dat/out_vld hold stable while out_vld & !out_rdy.
- Erase detection, on raw in_dat only (independent of bypass):
  - Each accept increments the word counter. It increments the non-FF counter when in_dat!=16'hFFFF; this counter saturates at ERASE_THR+1.
  - On the accept that makes the word counter = PAGE_WORDS:
    - page_done pulses next cycle.
    - page_erased <= (non-FF count including this word <= ERASE_THR).
    - Both counters wrap to 0.
  - The LFSR is not reseeded at the page boundary; it continues across pages until the next session start.
- Session start mid-page: counters clear, no page_done pulse, and the partial page is discarded.
- Asynchronous reset mid-transfer: all state returns to reset values immediately.

Test Plan:
- Seed 32'h00000001, bypass=0, feed four in_dat=16'h0000 with out_rdy=1 -> out_dat = 0000, 0003, 0000, 0006; each appears 1 cycle after its accept.
- Seed 32'h12345678, first in_dat=16'hFFFF -> out_dat=16'hEDCB. Then pulse en low/high and repeat -> identical 16'hEDCB, confirming reseed.
- bypass=1 for words 2-3 of the seed 32'h00000001 stream, in_dat=16'hA5A5 -> out 16'hA5A5 twice. After bypass drops, the next pattern is 0003 (LFSR frozen).
- Hold out_rdy=0 for 5 cycles with in_vld=1 -> one word is accepted, then in_rdy=0 and out_dat stays stable. Release -> no word lost or duplicated, and the pattern sequence is unchanged.
- PAGE_WORDS=8, ERASE_THR=1: page of 8x FFFF -> page_done pulse and page_erased=1. Next page with two non-FF words -> page_erased=0. Page with exactly one non-FF word -> page_erased=1.
- Drop en after 3 words of a page, then restart -> no page_done. The next page_done comes only after 8 fresh words.
